// File: rtl/hld_relock_ctrl.sv
// rtl/hld_relock_ctrl.sv - DLL delay-code owner that relocks on harmonic-lock detector requests
// Steps the delay code from PD up/dn, tracks lock, and reloads/blanks on Reset_PD.
module hld_relock_ctrl #(
  parameter int CODE_W     = 6,
  parameter int INIT_CODE  = 0,
  parameter int BLANK_CYC  = 8,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_RUN = 8,
  parameter int CNT_W      = 4
) (
  input  logic              clk_ext,
  input  logic              rst_n,
  input  logic              Reset_PD,
  input  logic              pd_up,
  input  logic              pd_dn,
  output logic [CODE_W-1:0] code,
  output logic              pd_en,
  output logic              locked,
  output logic [CNT_W-1:0]  relock_cnt
);

  localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int LCK_W = $clog2(LOCK_CNT + 1);
  localparam int RUN_W = $clog2(UNLOCK_RUN + 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_BLANK,
    S_TRACK,
    S_LOCKED
  } state_t;

  state_t state, state_d;

  logic              req_meta, req;
  logic [BLK_W-1:0]  blank_cnt, blank_d;
  logic [LCK_W-1:0]  lock_cnt, lock_d, lock_inc;
  logic [RUN_W-1:0]  run_cnt, run_d, run_inc;
  logic              dir_vld, dir_vld_d;
  logic              dir_up, dir_up_d;
  logic [CODE_W-1:0] code_d, step_code;
  logic              pd_en_d, locked_d;
  logic [CNT_W-1:0]  relock_d;

  logic up_s, dn_s, up_only, dn_only, is_dir, qual;

  // Reset_PD is an asynchronous level from the HLD.
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      req_meta <= 1'b0;
      req      <= 1'b0;
    end else begin
      req_meta <= Reset_PD;
      req      <= req_meta;
    end
  end

  assign up_s    = pd_en & pd_up;
  assign dn_s    = pd_en & pd_dn;
  assign up_only = up_s & ~dn_s;
  assign dn_only = dn_s & ~up_s;
  assign is_dir  = up_only | dn_only;
  // A directional step with no prior direction counts as same-direction.
  assign qual    = ~is_dir | (dir_vld & (dir_up != up_only));

  assign lock_inc = (lock_cnt == '1) ? lock_cnt : lock_cnt + LCK_W'(1);
  assign run_inc  = (run_cnt == '1) ? run_cnt : run_cnt + RUN_W'(1);

  always_comb begin
    step_code = code;
    if (up_only && code != '1) begin
      step_code = code + CODE_W'(1);
    end else if (dn_only && code != '0) begin
      step_code = code - CODE_W'(1);
    end
  end

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BLANK;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    code_d    = code;
    pd_en_d   = pd_en;
    locked_d  = locked;
    relock_d  = relock_cnt;
    blank_d   = blank_cnt;
    lock_d    = lock_cnt;
    run_d     = run_cnt;
    dir_vld_d = dir_vld;
    dir_up_d  = dir_up;
    case (state)
      S_INIT: begin
        blank_d = '0;
        state_d = S_BLANK;
      end
      S_BLANK: begin
        if (req) begin
          blank_d = '0;
        end else if (blank_cnt == BLK_W'(BLANK_CYC - 1)) begin
          blank_d = '0;
          pd_en_d = 1'b1;
          state_d = S_TRACK;
        end else begin
          blank_d = blank_cnt + BLK_W'(1);
        end
      end
      S_TRACK, S_LOCKED: begin
        if (req) begin
          // Reload takes effect on the edge entering INIT.
          state_d   = S_INIT;
          code_d    = CODE_W'(INIT_CODE);
          pd_en_d   = 1'b0;
          locked_d  = 1'b0;
          lock_d    = '0;
          run_d     = '0;
          dir_vld_d = 1'b0;
          dir_up_d  = 1'b0;
          if (relock_cnt != '1) begin
            relock_d = relock_cnt + CNT_W'(1);
          end
        end else begin
          code_d = step_code;
          if (is_dir) begin
            dir_vld_d = 1'b1;
            dir_up_d  = up_only;
          end
          if (qual) begin
            lock_d = lock_inc;
            run_d  = '0;
          end else begin
            lock_d = '0;
            run_d  = run_inc;
          end
          if (state == S_TRACK && qual && lock_inc == LCK_W'(LOCK_CNT)) begin
            locked_d = 1'b1;
            state_d  = S_LOCKED;
          end
          if (state == S_LOCKED && !qual && run_inc == RUN_W'(UNLOCK_RUN)) begin
            locked_d = 1'b0;
            lock_d   = '0;
            run_d    = '0;
            state_d  = S_TRACK;
          end
        end
      end
      default: begin
        state_d = S_BLANK;
        blank_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      code       <= CODE_W'(INIT_CODE);
      pd_en      <= 1'b0;
      locked     <= 1'b0;
      relock_cnt <= '0;
      blank_cnt  <= '0;
      lock_cnt   <= '0;
      run_cnt    <= '0;
      dir_vld    <= 1'b0;
      dir_up     <= 1'b0;
    end else begin
      code       <= code_d;
      pd_en      <= pd_en_d;
      locked     <= locked_d;
      relock_cnt <= relock_d;
      blank_cnt  <= blank_d;
      lock_cnt   <= lock_d;
      run_cnt    <= run_d;
      dir_vld    <= dir_vld_d;
      dir_up     <= dir_up_d;
    end
  end

endmodule

// File: tb/tb_hld_relock_ctrl.sv
// tb/tb_hld_relock_ctrl.sv - directed self-checking bench for hld_relock_ctrl
module tb_hld_relock_ctrl;

  logic       clk_ext  = 1'b0;
  logic       rst_n    = 1'b0;
  logic       Reset_PD = 1'b0;
  logic       pd_up    = 1'b0;
  logic       pd_dn    = 1'b0;
  logic [5:0] code;
  logic       pd_en;
  logic       locked;
  logic [3:0] relock_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk_ext = ~clk_ext;

  hld_relock_ctrl dut (
    .clk_ext    (clk_ext),
    .rst_n      (rst_n),
    .Reset_PD   (Reset_PD),
    .pd_up      (pd_up),
    .pd_dn      (pd_dn),
    .code       (code),
    .pd_en      (pd_en),
    .locked     (locked),
    .relock_cnt (relock_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int c, input int pe, input int lk, input int rc);
    chk({tag, ".code"}, 32'(code), c);
    chk({tag, ".pd_en"}, 32'(pd_en), pe);
    chk({tag, ".locked"}, 32'(locked), lk);
    chk({tag, ".relock_cnt"}, 32'(relock_cnt), rc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_ext);
    #1;
  endtask

  // One-cycle request from TRACK/LOCKED; returns once pd_en is back.
  task automatic relock(input int exp_rc);
    Reset_PD = 1'b1;
    tick(1);
    Reset_PD = 1'b0;
    tick(2);
    chk_out("relock_init", 0, 0, 0, exp_rc);
    tick(8);
    chk("relock_blank", 32'(pd_en), 0);
    tick(1);
    chk("relock_pd_en", 32'(pd_en), 1);
  endtask

  initial begin
    // Reset release with PD idle
    #12;
    chk_out("reset", 0, 0, 0, 0);
    @(posedge clk_ext);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk($sformatf("rst_blank%0d", k), 32'(pd_en), (k == 8) ? 1 : 0);
    end
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk($sformatf("hold_lock%0d", k), 32'(locked), (k == 4) ? 1 : 0);
    end
    chk_out("locked_idle", 0, 1, 1, 0);

    // One-cycle Reset_PD pulse while LOCKED
    Reset_PD = 1'b1;
    tick(1);
    Reset_PD = 1'b0;
    tick(1);
    chk("pulse_e2_locked", 32'(locked), 1);
    chk("pulse_e2_pd_en", 32'(pd_en), 1);
    tick(1);
    chk_out("pulse_e3", 0, 0, 0, 1);
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      chk($sformatf("pulse_blank%0d", k), 32'(pd_en), (k == 9) ? 1 : 0);
    end

    // Constant up: ramp to the top rail, never lock
    pd_up = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick(1);
      chk($sformatf("ramp_code%0d", k), 32'(code), (k < 63) ? k : 63);
      chk($sformatf("ramp_locked%0d", k), 32'(locked), 0);
    end
    pd_up = 1'b0;
    relock(2);

    // Up x10 then alternate dn/up
    pd_up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk($sformatf("up10_code%0d", k), 32'(code), k);
    end
    for (int k = 1; k <= 4; k++) begin
      pd_dn = (k % 2 == 1);
      pd_up = (k % 2 == 0);
      tick(1);
      chk($sformatf("alt_code%0d", k), 32'(code), (k % 2 == 1) ? 9 : 10);
      chk($sformatf("alt_locked%0d", k), 32'(locked), (k == 4) ? 1 : 0);
    end
    pd_up = 1'b0;
    pd_dn = 1'b0;

    // Lock at code 20 with last direction down, then run down 8
    relock(3);
    pd_up = 1'b1;
    tick(21);
    pd_up = 1'b0;
    chk("pre_run_code21", 32'(code), 21);
    pd_dn = 1'b1;
    tick(1);
    pd_dn = 1'b0;
    chk("pre_run_code20", 32'(code), 20);
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      chk($sformatf("pre_run_lock%0d", k), 32'(locked), (k == 3) ? 1 : 0);
    end
    pd_dn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk($sformatf("run_code%0d", k), 32'(code), 20 - k);
      chk($sformatf("run_locked%0d", k), 32'(locked), (k == 8) ? 0 : 1);
    end
    pd_dn = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk($sformatf("retrack_lock%0d", k), 32'(locked), (k == 4) ? 1 : 0);
    end

    // Reset_PD held for 20 cycles
    Reset_PD = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 3) chk_out("held_init", 0, 0, 0, 4);
      if (k > 3) chk($sformatf("held_pd_en%0d", k), 32'(pd_en), 0);
    end
    chk("held_relock_cnt", 32'(relock_cnt), 4);
    Reset_PD = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk($sformatf("release_pd_en%0d", k), 32'(pd_en), (k == 10) ? 1 : 0);
    end
    chk("release_relock_cnt", 32'(relock_cnt), 4);

    // Bottom rail, then async reset mid-TRACK
    pd_dn = 1'b1;
    tick(3);
    pd_dn = 1'b0;
    chk("floor_code", 32'(code), 0);
    chk("floor_locked", 32'(locked), 0);
    pd_up = 1'b1;
    tick(5);
    pd_up = 1'b0;
    chk("pre_rst_code", 32'(code), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    @(posedge clk_ext);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk($sformatf("rst2_blank%0d", k), 32'(pd_en), (k == 8) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
